aes_ctr_stream: RTL and testbench
=================================

Name: aes_ctr_stream

Overview:
- Parametrised successor to the single-block AES accelerator datapath controller.
- Runs a multi-block AES-CTR job over a word-wide memory: counter blocks are built from {nonce, ctr}, an external AES core encrypts each one, and the keystream is XORed with the plaintext words.
- Ciphertext words are written back to a second buffer.
- Keystream generation overlaps the plaintext fetch. The block sits between the memory port and the AES core and replaces the separate pre/post analysis pair.

Parameters:
- DATA_W, 32: memory word width. Legal values are 32, 64 or 128 (must divide 128). Words per block W = 128/DATA_W.
- ADDR_W, 12: word address width. Addresses wrap modulo 2^ADDR_W.
- LEN_W, 8: width of the block-count input.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request. Sampled only in IDLE.
- nonce  in  96  upper 96 bits of the counter block. Latched at start.
- ctr_init  in  32  initial counter value. Latched at start.
- num_blocks  in  LEN_W  number of 128-bit blocks in the job. Latched at start.
- plain_address  in  ADDR_W  first plaintext word address. Latched at start.
- cipher_address  in  ADDR_W  first ciphertext word address. Latched at start.
- read_en  out  1  memory read strobe.
- read_address  out  ADDR_W  read word address.
- read_data  in  DATA_W  read data, valid exactly 1 cycle after read_en.
- write_en  out  1  memory write strobe.
- write_address  out  ADDR_W  write word address.
- write_data  out  DATA_W  ciphertext word.
- core_start  out  1  one-cycle pulse to the AES core.
- core_din  out  128  counter block {nonce, ctr}. Held stable until core_valid.
- core_valid  in  1  one-cycle pulse; core_dout is valid in that cycle. Latency is arbitrary, at least 1 cycle.
- core_dout  in  128  keystream block.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job end.
- blocks_done  out  LEN_W  count of blocks written in the current/last job.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, and internal registers are cleared. RST during a job aborts it immediately: no further reads, writes or done pulse. A core_valid arriving after reset is ignored.
- Word order: the first word of a block maps to bits [127:128-DATA_W], i.e. big-endian. Ciphertext word i = plaintext word i XOR the matching keystream slice.
- States:
  - IDLE: on start, latch the inputs and clear blocks_done. If num_blocks == 0, go to DONE; otherwise go to ISSUE.
  - ISSUE (1 cycle): pulse core_start with core_din = {nonce_r, ctr_r}. Issue the first read. Go to READ.
  - READ: issue reads on consecutive cycles, W reads total per block with addresses incrementing by 1. Capture each read_data one cycle after its read into the block buffer. After the last capture, go to WAIT_KS.
  - WAIT_KS: if the keystream is already latched, or core_valid is high this cycle, go to WRITE. Otherwise stay.
  - WRITE: write W words on consecutive cycles to incrementing cipher addresses. On the last word: increment blocks_done, set ctr_r = ctr_r + 1 (mod 2^32, wrapping 0xFFFFFFFF to 0x00000000, nonce untouched), and advance the plain/cipher pointers. If blocks_done+1 == num_blocks_r, go to DONE; otherwise go to ISSUE.
  - DONE: pulse done for 1 cycle, drop busy, go to IDLE.
- Keystream: a core_valid during ISSUE/READ/WAIT_KS latches core_dout and sets ks_valid. ks_valid clears when WRITE completes. core_valid in any other state is ignored.
- Invariants: read_en and write_en are never high in the same cycle. start while busy is ignored. Addresses wrap modulo 2^ADDR_W. A block's reads and writes are never interleaved.
- Best-case per-block latency, with the core faster than W+1 cycles: 1 (ISSUE) + W (reads) + 1 (last capture / WAIT_KS) + W (writes) cycles.

Test Plan:
- DATA_W=32, num_blocks=1, nonce=0, ctr_init=0. Core model returns core_din XOR {32'hA5A5A5A5 x4} after 3 cycles. Plain words are 0x00000001..0x00000004 at address 0x010, cipher_address=0x100. Expected: four writes at 0x100..0x103 of 0xA5A5A5A4, 0xA5A5A5A7, 0xA5A5A5A6, 0xA5A5A5A1; then one done pulse with blocks_done=1.
- num_blocks=3, ctr_init=32'hFFFFFFFF. Expected: core_din low words are FFFFFFFF, 00000000, 00000001 with the nonce unchanged. Reads cover 12 consecutive addresses and writes cover 12 consecutive addresses.
- Core latency 20 cycles. Expected: FSM holds in WAIT_KS with no strobes until core_valid, then writes immediately. With core latency 1, core_valid arrives during READ and is latched; WAIT_KS lasts 1 cycle.
- num_blocks=0. Expected: done pulses 2 cycles after start with no read_en, write_en or core_start. A start issued while busy is ignored, and exactly one done is produced.
- plain_address=0xFFE, DATA_W=32. Expected: read addresses 0xFFE, 0xFFF, 0x000, 0x001. Separately, DATA_W=128 gives W=1 with one read and one write per block.
- RST asserted mid-WRITE. Expected: the next cycle has all outputs 0 and the FSM in IDLE, no done pulse follows, and a fresh start afterwards runs cleanly.

Source files
------------

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: multi-block AES-CTR job controller between a word-wide
// memory port and an external AES core.
//
// For each 128-bit block it issues the counter block {nonce, ctr} to the
// core, fetches W = 128/DATA_W plaintext words while the core works, waits
// for the keystream, then writes W ciphertext words (plaintext XOR keystream).
// Word 0 of a block maps to bits [127 -: DATA_W] (big-endian).
//
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   start               one-cycle job request, sampled only in IDLE
//   nonce, ctr_init     counter block fields, latched at start
//   num_blocks          blocks in the job, latched at start (0 = empty job)
//   plain_address       first plaintext word address, latched at start
//   cipher_address      first ciphertext word address, latched at start
//   read_en/_address    memory read strobe/address; read_data valid 1 cycle later
//   write_en/_address/_data  ciphertext write port
//   core_start/core_din core request pulse and counter block (held until core_valid)
//   core_valid/core_dout keystream return pulse and data
//   busy, done          job in flight / one-cycle end-of-job pulse
//   blocks_done         blocks written in the current/last job
//   fsm_state_o         current FSM state (debug visibility)
//
// Core handshake: core_start is a one-cycle request carrying core_din; the
// core answers with exactly one core_valid pulse some cycles later. A
// core_valid is accepted only while a request is outstanding and the FSM is
// in ISSUE, READ or WAIT_KS; anything else (including replies to a request
// aborted by reset) is dropped.
module aes_ctr_stream #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [95:0]       nonce,
  input  logic [31:0]       ctr_init,
  input  logic [LEN_W-1:0]  num_blocks,
  input  logic [ADDR_W-1:0] plain_address,
  input  logic [ADDR_W-1:0] cipher_address,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              core_start,
  output logic [127:0]      core_din,
  input  logic              core_valid,
  input  logic [127:0]      core_dout,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  blocks_done,
  output logic [2:0]        fsm_state_o
);

  localparam int W     = 128 / DATA_W;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_READ    = 3'd2,
    S_WAIT_KS = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [95:0]         nonce_q;
  logic [31:0]         ctr_q;
  logic [LEN_W-1:0]    num_blocks_q;
  logic [LEN_W-1:0]    blocks_done_q;
  logic [ADDR_W-1:0]   plain_ptr_q;
  logic [ADDR_W-1:0]   cipher_ptr_q;
  logic [CNT_W-1:0]    word_q;       // word index within the block (read or write phase)
  logic [127:0]        ks_q;
  logic                ks_valid_q;
  logic                core_pend_q;  // a core request is outstanding
  logic [DATA_W-1:0]   buf_q [W];
  logic [DATA_W-1:0]   ks_word [W];

  logic                ks_accept;
  logic                word_last;
  logic [LEN_W-1:0]    blocks_inc;

  for (genvar k = 0; k < W; k++) begin : g_ks_word
    assign ks_word[k] = ks_q[127 - k*DATA_W -: DATA_W];
  end

  assign ks_accept  = core_valid && core_pend_q &&
                      (state_q inside {S_ISSUE, S_READ, S_WAIT_KS});
  assign word_last  = (word_q == LAST);
  assign blocks_inc = blocks_done_q + LEN_W'(1);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (num_blocks == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:   state_d = S_READ;
      S_READ:    if (word_last) state_d = S_WAIT_KS;
      S_WAIT_KS: if (ks_valid_q || ks_accept) state_d = S_WRITE;
      S_WRITE:   if (word_last) state_d = (blocks_inc == num_blocks_q) ? S_DONE : S_ISSUE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs. ISSUE issues read 0; READ cycle k captures word k and issues
  // read k+1, so the final READ cycle only captures.
  always_comb begin
    read_en       = 1'b0;
    read_address  = '0;
    write_en      = 1'b0;
    write_address = '0;
    write_data    = '0;
    core_start    = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_ISSUE: begin
        core_start   = 1'b1;
        read_en      = 1'b1;
        read_address = plain_ptr_q;
      end
      S_READ: begin
        if (!word_last) begin
          read_en      = 1'b1;
          read_address = plain_ptr_q + ADDR_W'(word_q) + ADDR_W'(1);
        end
      end
      S_WRITE: begin
        write_en      = 1'b1;
        write_address = cipher_ptr_q + ADDR_W'(word_q);
        write_data    = buf_q[word_q] ^ ks_word[word_q];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy        = state_q inside {S_ISSUE, S_READ, S_WAIT_KS, S_WRITE};
  assign core_din    = {nonce_q, ctr_q};
  assign blocks_done = blocks_done_q;
  assign fsm_state_o = state_q;

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      nonce_q       <= '0;
      ctr_q         <= '0;
      num_blocks_q  <= '0;
      blocks_done_q <= '0;
      plain_ptr_q   <= '0;
      cipher_ptr_q  <= '0;
      word_q        <= '0;
      ks_q          <= '0;
      ks_valid_q    <= 1'b0;
      core_pend_q   <= 1'b0;
      for (int k = 0; k < W; k++) buf_q[k] <= '0;
    end else begin
      if (ks_accept) begin
        ks_q        <= core_dout;
        ks_valid_q  <= 1'b1;
        core_pend_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            nonce_q       <= nonce;
            ctr_q         <= ctr_init;
            num_blocks_q  <= num_blocks;
            plain_ptr_q   <= plain_address;
            cipher_ptr_q  <= cipher_address;
            blocks_done_q <= '0;
            word_q        <= '0;
            ks_valid_q    <= 1'b0;
          end
        end
        S_ISSUE: begin
          word_q      <= '0;
          core_pend_q <= 1'b1;
        end
        S_READ: begin
          buf_q[word_q] <= read_data;
          word_q        <= word_last ? '0 : word_q + CNT_W'(1);
        end
        S_WRITE: begin
          if (word_last) begin
            word_q        <= '0;
            blocks_done_q <= blocks_inc;
            ctr_q         <= ctr_q + 32'd1;
            plain_ptr_q   <= plain_ptr_q + ADDR_W'(W);
            cipher_ptr_q  <= cipher_ptr_q + ADDR_W'(W);
            ks_valid_q    <= 1'b0;
          end else begin
            word_q <= word_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Bench for aes_ctr_stream: a 32-bit instance carries most scenarios, a
// 128-bit instance covers the one-word-per-block case.
module tb_aes_ctr_stream;

  localparam logic [127:0] PAT = {4{32'hA5A5A5A5}};
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- shared job inputs ----------------
  logic [95:0] nonce_i;
  logic [31:0] ctr_i;
  logic [7:0]  nblk_i;
  logic [11:0] pa_i, ca_i;

  // ---------------- 32-bit instance ----------------
  logic         start_a, read_en_a, write_en_a, core_start_a, core_valid_a, busy_a, done_a;
  logic [11:0]  read_addr_a, write_addr_a;
  logic [31:0]  read_data_a, write_data_a;
  logic [127:0] core_din_a, core_dout_a;
  logic [7:0]   blocks_done_a;
  logic [2:0]   state_a;

  aes_ctr_stream #(.DATA_W(32), .ADDR_W(12), .LEN_W(8)) dut (
    .CLK(CLK), .RST(RST), .start(start_a), .nonce(nonce_i), .ctr_init(ctr_i),
    .num_blocks(nblk_i), .plain_address(pa_i), .cipher_address(ca_i),
    .read_en(read_en_a), .read_address(read_addr_a), .read_data(read_data_a),
    .write_en(write_en_a), .write_address(write_addr_a), .write_data(write_data_a),
    .core_start(core_start_a), .core_din(core_din_a), .core_valid(core_valid_a),
    .core_dout(core_dout_a), .busy(busy_a), .done(done_a),
    .blocks_done(blocks_done_a), .fsm_state_o(state_a)
  );

  // ---------------- 128-bit instance ----------------
  logic         start_b, read_en_b, write_en_b, core_start_b, core_valid_b, busy_b, done_b;
  logic [11:0]  read_addr_b, write_addr_b;
  logic [127:0] read_data_b, write_data_b;
  logic [127:0] core_din_b, core_dout_b;
  logic [7:0]   blocks_done_b;
  logic [2:0]   state_b;

  aes_ctr_stream #(.DATA_W(128), .ADDR_W(12), .LEN_W(8)) dut_b (
    .CLK(CLK), .RST(RST), .start(start_b), .nonce(nonce_i), .ctr_init(ctr_i),
    .num_blocks(nblk_i), .plain_address(pa_i), .cipher_address(ca_i),
    .read_en(read_en_b), .read_address(read_addr_b), .read_data(read_data_b),
    .write_en(write_en_b), .write_address(write_addr_b), .write_data(write_data_b),
    .core_start(core_start_b), .core_din(core_din_b), .core_valid(core_valid_b),
    .core_dout(core_dout_b), .busy(busy_b), .done(done_b),
    .blocks_done(blocks_done_b), .fsm_state_o(state_b)
  );

  // ---------------- memory and core models ----------------
  logic [31:0] mem [4096];
  int core_lat = 3;
  int cnt_a = 0;
  int cnt_b = 0;
  logic [127:0] held_a, held_b;

  function automatic logic [127:0] plain128(input logic [11:0] a);
    return {4{20'h0, a}} ^ 128'h0123456789ABCDEF_FEDCBA9876543210;
  endfunction

  always @(posedge CLK) begin
    if (read_en_a) read_data_a <= mem[read_addr_a];
    if (read_en_b) read_data_b <= plain128(read_addr_b);
  end

  // Core returns din ^ PAT, core_lat cycles after core_start (>= 1).
  always @(posedge CLK) begin
    core_valid_a <= 1'b0;
    if (core_start_a) begin
      held_a <= core_din_a;
      if (core_lat == 1) begin
        core_valid_a <= 1'b1;
        core_dout_a  <= core_din_a ^ PAT;
      end else cnt_a <= core_lat - 1;
    end else if (cnt_a != 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) begin
        core_valid_a <= 1'b1;
        core_dout_a  <= held_a ^ PAT;
      end
    end
  end

  always @(posedge CLK) begin
    core_valid_b <= 1'b0;
    if (core_start_b) begin
      held_b <= core_din_b;
      cnt_b  <= 1;
    end else if (cnt_b != 0) begin
      cnt_b        <= 0;
      core_valid_b <= 1'b1;
      core_dout_b  <= held_b ^ PAT;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [11:0]  exp_rd_q [$];
  logic [43:0]  exp_wr_q [$];
  logic [127:0] exp_din_q [$];
  logic [11:0]  rd_log [$];
  logic [43:0]  wr_log [$];
  logic [127:0] din_log [$];
  logic [11:0]  exp_rd_b [$];
  logic [139:0] exp_wr_b [$];
  logic [7:0]   exp_blocks = 0;
  bit           job_active = 0;
  int           done_cnt = 0;
  int           done_b_cnt = 0;
  int           t_issue = 0;
  bit           first_w = 0;
  int           wait_run = 0;

  // Expected job for the 32-bit instance, straight from the CTR definition.
  task automatic model_job(input logic [95:0] nn, input logic [31:0] cc, input int n,
                           input logic [11:0] pa, input logic [11:0] ca);
    logic [127:0] ks;
    logic [31:0]  c;
    logic [11:0]  ra, wa;
    for (int b = 0; b < n; b++) begin
      c  = cc + 32'(b);
      exp_din_q.push_back({nn, c});
      ks = {nn, c} ^ PAT;
      for (int i = 0; i < 4; i++) begin
        ra = pa + 12'(4*b + i);
        wa = ca + 12'(4*b + i);
        exp_rd_q.push_back(ra);
        exp_wr_q.push_back({wa, mem[ra] ^ ks[127 - 32*i -: 32]});
      end
    end
  endtask

  // Per-cycle compare for the 32-bit instance.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("strobe_rules", (read_en_a && write_en_a) ||
          (state_a == ST_WAIT && (read_en_a || write_en_a || core_start_a)), 1'b0);
      if (core_start_a) begin
        chk("din_avail", exp_din_q.size() != 0, 1'b1);
        if (exp_din_q.size() != 0) chk("core_din", core_din_a, exp_din_q.pop_front());
        din_log.push_back(core_din_a);
        t_issue  = cyc;
        first_w  = 1'b1;
        wait_run = 0;
      end
      if (state_a == ST_WAIT) wait_run++;
      if (read_en_a) begin
        chk("rd_avail", exp_rd_q.size() != 0, 1'b1);
        if (exp_rd_q.size() != 0) chk("read_address", read_addr_a, exp_rd_q.pop_front());
        rd_log.push_back(read_addr_a);
      end
      if (write_en_a) begin
        chk("wr_avail", exp_wr_q.size() != 0, 1'b1);
        if (exp_wr_q.size() != 0) chk("write_addr_data", {write_addr_a, write_data_a}, exp_wr_q.pop_front());
        wr_log.push_back({write_addr_a, write_data_a});
        if (first_w) begin
          // ISSUE + 4 read cycles + 1 WAIT_KS at best, else one cycle after core_valid.
          chk("issue_to_write", cyc - t_issue, (core_lat + 1 > 6) ? core_lat + 1 : 6);
          first_w = 1'b0;
        end
      end
      if (done_a) begin
        done_cnt++;
        chk("done_expected", job_active, 1'b1);
        chk("blocks_done", blocks_done_a, exp_blocks);
        chk("done_wr_left", exp_wr_q.size(), 0);
      end
    end
  end

  // Per-cycle compare for the 128-bit instance.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("b_strobe_rules", read_en_b && write_en_b, 1'b0);
      if (read_en_b) begin
        chk("b_rd_avail", exp_rd_b.size() != 0, 1'b1);
        if (exp_rd_b.size() != 0) chk("b_read_address", read_addr_b, exp_rd_b.pop_front());
      end
      if (write_en_b) begin
        chk("b_wr_avail", exp_wr_b.size() != 0, 1'b1);
        if (exp_wr_b.size() != 0) chk("b_write", {write_addr_b, write_data_b}, exp_wr_b.pop_front());
      end
      if (done_b) begin
        done_b_cnt++;
        chk("b_blocks_done", blocks_done_b, 8'd2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [95:0] nn, input logic [31:0] cc, input logic [7:0] n,
                             input logic [11:0] pa, input logic [11:0] ca);
    @(posedge CLK); #1;
    nonce_i = nn; ctr_i = cc; nblk_i = n; pa_i = pa; ca_i = ca;
    start_a = 1'b1;
    @(posedge CLK); #1;
    start_a = 1'b0;
  endtask

  task automatic run_job(input logic [95:0] nn, input logic [31:0] cc, input logic [7:0] n,
                         input logic [11:0] pa, input logic [11:0] ca, input int lat, input bit poke);
    core_lat   = lat;
    rd_log.delete(); wr_log.delete(); din_log.delete();
    model_job(nn, cc, int'(n), pa, ca);
    exp_blocks = n;
    done_cnt   = 0;
    job_active = 1'b1;
    drive_start(nn, cc, n, pa, ca);
    @(negedge CLK);
    if (n == 0) chk("zero_done_timing", done_a, 1'b1);
    if (poke) begin
      repeat (5) @(posedge CLK);
      #1 nblk_i = 8'd9; start_a = 1'b1;
      @(posedge CLK); #1 start_a = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge CLK);
    repeat (10) @(posedge CLK);
    chk("done_count", done_cnt, 1);
    chk("rd_left", exp_rd_q.size(), 0);
    chk("din_left", exp_din_q.size(), 0);
    job_active = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [127:0] d;
  logic [127:0] ksb;
  initial begin
    start_a = 0; start_b = 0;
    nonce_i = '0; ctr_i = '0; nblk_i = '0; pa_i = '0; ca_i = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    for (int i = 0; i < 4; i++) mem[12'h010 + i] = 32'(i + 1);

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_outputs", {read_en_a, read_addr_a, write_en_a, write_addr_a, write_data_a,
        core_start_a, busy_a, done_a, blocks_done_a, state_a}, '0);
    chk("reset_core_din", core_din_a, '0);

    // One block, literal ciphertext.
    run_job('0, 32'h0, 8'd1, 12'h010, 12'h100, 3, 1'b0);
    chk("t1_wr_count", wr_log.size(), 4);
    chk("t1_w0", wr_log[0], {12'h100, 32'hA5A5A5A4});
    chk("t1_w1", wr_log[1], {12'h101, 32'hA5A5A5A7});
    chk("t1_w2", wr_log[2], {12'h102, 32'hA5A5A5A6});
    chk("t1_w3", wr_log[3], {12'h103, 32'hA5A5A5A1});
    chk("t1_blocks_done", blocks_done_a, 8'd1);

    // Counter wrap across three blocks.
    run_job(96'h0123_4567_89AB_CDEF_0011_2233, 32'hFFFF_FFFF, 8'd3, 12'h200, 12'h300, 3, 1'b0);
    chk("t2_din_count", din_log.size(), 3);
    d = din_log[0]; chk("t2_ctr0", d[31:0], 32'hFFFF_FFFF);
    d = din_log[1]; chk("t2_ctr1", d[31:0], 32'h0000_0000);
    chk("t2_nonce1", d[127:32], 96'h0123_4567_89AB_CDEF_0011_2233);
    d = din_log[2]; chk("t2_ctr2", d[31:0], 32'h0000_0001);
    chk("t2_rd_count", rd_log.size(), 12);
    chk("t2_rd_last", rd_log[11], 12'h20B);
    chk("t2_wr_count", wr_log.size(), 12);

    // Slow core: WAIT_KS holds 16 cycles (ISSUE at c, WAIT_KS c+5..c+20).
    run_job(96'h5, 32'h10, 8'd1, 12'h020, 12'h120, 20, 1'b0);
    chk("t3_wait_slow", wait_run, 16);
    // Fast core: keystream latched during READ, WAIT_KS lasts one cycle.
    run_job(96'h6, 32'h20, 8'd2, 12'h030, 12'h130, 1, 1'b0);
    chk("t3_wait_fast", wait_run, 1);

    // Empty job, then start while busy is ignored.
    run_job(96'h7, 32'h30, 8'd0, 12'h040, 12'h140, 3, 1'b0);
    chk("t4_zero_reads", rd_log.size(), 0);
    run_job(96'h8, 32'h40, 8'd2, 12'h050, 12'h150, 3, 1'b1);

    // Address wrap on both ports.
    run_job(96'h9, 32'h50, 8'd1, 12'hFFE, 12'hFFF, 3, 1'b0);
    chk("t5_rd0", rd_log[0], 12'hFFE);
    chk("t5_rd2", rd_log[2], 12'h000);
    chk("t5_rd3", rd_log[3], 12'h001);

    // Reset in the middle of WRITE.
    core_lat = 3;
    model_job(96'hA, 32'h60, 2, 12'h060, 12'h160);
    exp_blocks = 8'd2; done_cnt = 0; job_active = 1'b1;
    drive_start(96'hA, 32'h60, 8'd2, 12'h060, 12'h160);
    for (int i = 0; i < 200 && state_a != ST_WRITE; i++) @(negedge CLK);
    chk("t6_reached_write", state_a, ST_WRITE);
    @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b1;
    exp_rd_q.delete(); exp_wr_q.delete(); exp_din_q.delete();
    job_active = 1'b0;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("t6_rst_outputs", {read_en_a, read_addr_a, write_en_a, write_addr_a, write_data_a,
        core_start_a, busy_a, done_a, blocks_done_a, state_a}, '0);
    chk("t6_rst_core_din", core_din_a, '0);
    chk("t6_rst_state", state_a, ST_IDLE);
    repeat (30) @(posedge CLK);
    chk("t6_no_done", done_cnt, 0);
    run_job(96'hB, 32'h70, 8'd2, 12'h070, 12'h170, 3, 1'b0);

    // DATA_W = 128: one read and one write per block.
    for (int b = 0; b < 2; b++) begin
      exp_rd_b.push_back(12'h7FF + 12'(b));
      ksb = {96'hC, 32'h5 + 32'(b)} ^ PAT;
      exp_wr_b.push_back({12'h020 + 12'(b), plain128(12'h7FF + 12'(b)) ^ ksb});
    end
    @(posedge CLK); #1;
    nonce_i = 96'hC; ctr_i = 32'h5; nblk_i = 8'd2; pa_i = 12'h7FF; ca_i = 12'h020;
    start_b = 1'b1;
    @(posedge CLK); #1 start_b = 1'b0;
    for (int i = 0; i < 500 && done_b_cnt == 0; i++) @(posedge CLK);
    repeat (5) @(posedge CLK);
    chk("b_done_count", done_b_cnt, 1);
    chk("b_rd_left", exp_rd_b.size(), 0);
    chk("b_wr_left", exp_wr_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
